ex_mul_div: RTL and testbench

//  Multi-cycle multiply/divide unit in the EX stage. Consumes funct/operands

---
 rtl/ex_mul_div_if.sv | 24 ++
 rtl/ex_mul_div.sv | 150 +++++++++++++++
 tb/tb_ex_mul_div.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ex_mul_div_if.sv
// rtl/ex_mul_div_if.sv - ID/EX-side handshake and HI/LO result bundle for the mul/div unit
interface ex_mul_div_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       funct_in;
  logic [WIDTH-1:0] operand_1_in;
  logic [WIDTH-1:0] operand_2_in;
  logic             flush;
  logic             stall_request;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output funct_in, operand_1_in, operand_2_in, flush,
    input  stall_request, busy, result_valid, hi_out, lo_out
  );

  modport slave (
    input  funct_in, operand_1_in, operand_2_in, flush,
    output stall_request, busy, result_valid, hi_out, lo_out
  );
endinterface

// File: rtl/ex_mul_div.sv
// rtl/ex_mul_div.sv - iterative EX-stage multiply/divide unit producing {hi,lo}
module ex_mul_div #(
  parameter int         WIDTH       = 32,
  parameter logic [5:0] FUNCT_MULT  = 6'h18,
  parameter logic [5:0] FUNCT_MULTU = 6'h19,
  parameter logic [5:0] FUNCT_DIV   = 6'h1a,
  parameter logic [5:0] FUNCT_DIVU  = 6'h1b
) (
  input logic        clk,
  input logic        rst,
  ex_mul_div_if.slave md
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mag1_q, mag1_d, mag2_q, mag2_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               is_div_q, is_div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               known, is_signed, op_div, start, s1, s2, div_ge, res_valid;
  logic [WIDTH:0]     abs1, abs2, trial, div_sub;
  logic [2*WIDTH-1:0] mul_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  always_comb begin
    known     = (md.funct_in == FUNCT_MULT) || (md.funct_in == FUNCT_MULTU) ||
                (md.funct_in == FUNCT_DIV)  || (md.funct_in == FUNCT_DIVU);
    is_signed = (md.funct_in == FUNCT_MULT) || (md.funct_in == FUNCT_DIV);
    op_div    = (md.funct_in == FUNCT_DIV)  || (md.funct_in == FUNCT_DIVU);
    start     = (state_q == S_IDLE) && !md.flush && known;
    s1        = is_signed && md.operand_1_in[WIDTH-1];
    s2        = is_signed && md.operand_2_in[WIDTH-1];
    // One extra magnitude bit keeps |most-negative| exact.
    abs1      = s1 ? -{1'b1, md.operand_1_in} : {1'b0, md.operand_1_in};
    abs2      = s2 ? -{1'b1, md.operand_2_in} : {1'b0, md.operand_2_in};

    mul_next  = {acc_q[2*WIDTH-2:0], 1'b0} +
                (mag2_q[WIDTH-1] ? {{(WIDTH-1){1'b0}}, mag1_q} : '0);
    // Restoring divide: acc holds {remainder, dividend/quotient shift register}.
    trial     = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = (trial >= mag2_q);
    div_sub   = trial - mag2_q;

    prod_fix  = qneg_q ? -acc_q : acc_q;
    quo_fix   = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (dz_q) begin
      res_hi = acc_q[2*WIDTH-1:WIDTH];
      res_lo = acc_q[WIDTH-1:0];
    end else if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
    res_valid = (state_q == S_DONE) && !md.flush;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mag1_d   = mag1_q;
    mag2_d   = mag2_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d    = '0;
          mag1_d   = abs1;
          mag2_d   = abs2;
          is_div_d = op_div;
          qneg_d   = s1 ^ s2;
          rneg_d   = s1;
          dz_d     = op_div && (md.operand_2_in == '0);
          if (op_div && (md.operand_2_in == '0)) begin
            acc_d   = {md.operand_1_in, {WIDTH{1'b1}}};
            state_d = S_DONE;
          end else begin
            acc_d   = op_div ? {{WIDTH{1'b0}}, abs1[WIDTH-1:0]} : '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (is_div_q) begin
          acc_d = div_ge ? {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                         : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d  = mul_next;
          mag2_d = mag2_q << 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (md.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mag1_q   <= '0;
      mag2_q   <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mag1_q   <= mag1_d;
      mag2_q   <= mag2_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      if (res_valid) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  // Result is presented in the DONE cycle itself and then held in hi_q/lo_q.
  assign md.result_valid  = res_valid;
  assign md.hi_out        = res_valid ? res_hi : hi_q;
  assign md.lo_out        = res_valid ? res_lo : lo_q;
  assign md.busy          = (state_q != S_IDLE);
  assign md.stall_request = !rst && !md.flush && (start || (state_q == S_BUSY));
endmodule

// File: tb/tb_ex_mul_div.sv
// tb/tb_ex_mul_div.sv - randomized self-checking bench for ex_mul_div against an arithmetic model
module tb_ex_mul_div;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  ex_mul_div_if #(.WIDTH(32)) md();
  ex_mul_div dut (.clk(clk), .rst(rst), .md(md));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (f)
      F_MULT:  p = sa * sb;
      F_MULTU: p = {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [63:0] e;
    int stall_cnt, vcyc, lat;
    logic [31:0] gh, gl;
    e = model(f, a, b);
    lat = ((f == F_DIV || f == F_DIVU) && b == 0) ? 1 : 33;
    @(posedge clk); #1;
    md.funct_in = f; md.operand_1_in = a; md.operand_2_in = b;
    stall_cnt = 0; vcyc = -1; gh = '0; gl = '0;
    for (int n = 0; n < 40 && vcyc < 0; n++) begin
      @(negedge clk);
      if (md.stall_request) stall_cnt++;
      if (md.result_valid) begin
        vcyc = n; gh = md.hi_out; gl = md.lo_out;
      end
    end
    if (!hold) md.funct_in = 6'h00;
    check($sformatf("latency f=%h", f), 64'(vcyc), 64'(lat));
    check($sformatf("stall_cycles f=%h", f), 64'(stall_cnt), 64'(lat));
    check($sformatf("hi f=%h a=%h b=%h", f, a, b), 64'(gh), 64'(e[63:32]));
    check($sformatf("lo f=%h a=%h b=%h", f, a, b), 64'(gl), 64'(e[31:0]));
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  initial begin
    int vcnt;
    logic [5:0] f;
    logic [31:0] a, b;
    md.funct_in = '0; md.operand_1_in = '0; md.operand_2_in = '0; md.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 64'(md.stall_request), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(md.busy), 64'd0);
    check("reset_valid", 64'(md.result_valid), 64'd0);
    check("reset_hilo", {md.hi_out, md.lo_out}, 64'd0);

    run_op(F_MULT,  32'd7,         32'hFFFF_FFFD, 1'b0);
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(F_DIVU,  32'd100,       32'd7,         1'b0);
    run_op(F_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(F_DIV,   32'd5,         32'd0,         1'b0);
    run_op(F_DIVU,  32'hDEAD_BEEF, 32'd0,         1'b0);
    run_op(F_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      f = F_MULT + 6'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 300));
      run_op(f, a, b, 1'b0);
    end

    // Flush mid-multiply: nothing observable may change.
    @(posedge clk); #1;
    md.funct_in = F_MULT; md.operand_1_in = 32'd12345; md.operand_2_in = 32'd678;
    repeat (10) @(posedge clk);
    #1;
    md.flush = 1'b1; md.funct_in = 6'h00;
    @(negedge clk);
    check("flush_stall", 64'(md.stall_request), 64'd0);
    @(posedge clk); #1;
    md.flush = 1'b0;
    @(negedge clk);
    check("flush_idle", 64'(md.busy), 64'd0);
    vcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (md.result_valid) vcnt++;
    end
    check("flush_no_valid", 64'(vcnt), 64'd0);
    check("flush_hilo_kept", {md.hi_out, md.lo_out}, {exp_hi, exp_lo});

    // Asynchronous reset in the middle of an iteration.
    @(posedge clk); #1;
    md.funct_in = F_MULTU; md.operand_1_in = 32'h1234_5678; md.operand_2_in = 32'h9ABC_DEF0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_busy", 64'(md.busy), 64'd0);
    check("midreset_stall", 64'(md.stall_request), 64'd0);
    check("midreset_valid", 64'(md.result_valid), 64'd0);
    check("midreset_hilo", {md.hi_out, md.lo_out}, 64'd0);
    md.funct_in = 6'h00;
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back: ID/EX keeps the MULT; second one must start right after DONE.
    run_op(F_MULT, 32'hFFFF_FF00, 32'd300, 1'b1);
    run_op(F_MULT, 32'hFFFF_FF00, 32'd300, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
